cond_branch_resolver: RTL and testbench
=======================================

Name: cond_branch_resolver

Overview:
- Consumes the single-bit zero flag produced by the N-bit zero checker, plus the ALU's N/C/V bits, and holds the architectural NZCV flag register.
- Resolves B.cond, CBZ, CBNZ and B requests into a registered taken/not-taken decision for the fetch stage.
- Also keeps a saturating count of taken branches for the performance counters.
- Sits between the execute stage (flag producers) and the PC-select logic.

Parameters:
- BYPASS, 1: 1 means a B.cond evaluates against flags being written in the same cycle; 0 means it uses the stored flags.
- COUNT_WIDTH, 16: width of the taken-branch counter.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- set_flags_i  input  1  write NZCV this cycle (ADDS/SUBS/ANDS).
- zero_i  input  1  Z from the ALU-result zero checker.
- negative_i  input  1  N, the ALU result MSB.
- carry_i  input  1  C from the ALU.
- overflow_i  input  1  V from the ALU.
- br_valid_i  input  1  branch request present this cycle.
- br_type_i  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional).
- cond_i  input  4  condition code for B.cond; ignored for other types.
- reg_zero_i  input  1  zero-checker flag of the CBZ/CBNZ register operand.
- flush_i  input  1  squash the in-flight request and the pending output.
- flags_o  output  4  stored flags, bit order {N,Z,C,V}.
- br_done_o  output  1  decision valid; 1-cycle pulse.
- br_taken_o  output  1  decision; meaningful only while br_done_o=1, 0 otherwise.
- taken_count_o  output  COUNT_WIDTH  saturating count of taken branches.

Behaviour:
- Synchronous, active-high reset: next edge forces flags_o=4'b0000, br_done_o=0, br_taken_o=0, taken_count_o=0.
  - Reset overrides every other input, including a request or set_flags in the same cycle.
  - Reset mid-operation drops any pending decision.
- Flag register: on an edge with set_flags_i=1, flags_o <= {negative_i, zero_i, carry_i, overflow_i}; otherwise flags_o holds.
- Evaluation flags F:
  - BYPASS=1 and set_flags_i=1: F = incoming bits.
  - Otherwise: F = flags_o.
- Condition table for B.cond:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C & !Z.
  - 1001 LS: !C | Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V).
  - 1101 LE: Z | (N!=V).
  - 1110 and 1111: always taken.
- Taken rule by type:
  - CBZ: taken = reg_zero_i.
  - CBNZ: taken = !reg_zero_i.
  - B: always taken.
  - CBZ, CBNZ and B ignore F and cond_i.
- Latency: one cycle. A request sampled at edge k (br_valid_i=1, flush_i=0) produces br_done_o=1 and br_taken_o for the cycle after edge k.
  - Both outputs return to 0 on the following edge unless a new request arrives.
- Back-to-back: one request per cycle accepted with no stall; outputs are fully registered.
- State machine, states IDLE and DONE, registered in br_done_o:
  - IDLE -> DONE on an accepted request.
  - DONE -> DONE on another accepted request.
  - DONE -> IDLE otherwise.
- Flush:
  - flush_i=1 at an edge: the request sampled at that edge is discarded, and br_done_o/br_taken_o are 0 after that edge.
  - An already-visible decision is not retracted combinationally.
  - Flush does not block set_flags_i: flags are still written.
  - Flush does not change taken_count_o.
- Counter: increments by 1 on each edge that registers br_taken_o=1.
  - Saturates at all-ones with no wrap.
  - Counts only accepted, unflushed taken decisions.
- No X propagation: with br_valid_i=0, cond_i, br_type_i and reg_zero_i are don't-care and must not affect the outputs.

Test Plan:
1. Reset, then set_flags_i=1 with N,Z,C,V=0,1,0,0, then B.cond EQ (0000) next cycle -> flags_o=4'b0100; one cycle later br_done_o=1, br_taken_o=1; taken_count_o=1.
2. Bypass (BYPASS=1): flags_o=0100; in the same cycle set_flags_i=1 with Z=0, N=1, V=0 and B.cond LT (1011) -> taken=1. Repeat with BYPASS=0 -> LT evaluates on stored N=0,V=0 and gives taken=0.
3. CBZ/CBNZ back-to-back over three cycles: CBZ with reg_zero_i=1, CBNZ with reg_zero_i=1, B -> br_done_o=1 for three consecutive cycles, br_taken_o sequence 1,0,1, taken_count_o +2.
4. Condition sweep: for each NZCV in {0000, 0100, 1000, 0001, 1001, 0010, 0110} and all 16 cond_i values -> br_taken_o matches the table (e.g. NZCV=1001: GE=1, GT=1, LT=0).
5. Flush/reset: request plus flush_i=1 in the same cycle -> br_done_o stays 0 and the count is unchanged, but a set_flags_i in the same cycle still updates flags_o. reset_i asserted while br_done_o=1 -> all outputs 0 after the edge.
6. Saturation with COUNT_WIDTH=4: 17 taken B requests -> taken_count_o reaches 4'hF and stays at 4'hF.

Source files
------------

// File: rtl/cond_branch_resolver.sv
// Holds the NZCV flag register and turns B.cond/CBZ/CBNZ/B requests into a
// registered one-cycle taken/not-taken pulse, plus a saturating taken counter.
module cond_branch_resolver #(
    parameter bit BYPASS      = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   set_flags_i,
    input  logic                   zero_i,
    input  logic                   negative_i,
    input  logic                   carry_i,
    input  logic                   overflow_i,
    input  logic                   br_valid_i,
    input  logic [1:0]             br_type_i,
    input  logic [3:0]             cond_i,
    input  logic                   reg_zero_i,
    input  logic                   flush_i,
    output logic [3:0]             flags_o,
    output logic                   br_done_o,
    output logic                   br_taken_o,
    output logic [COUNT_WIDTH-1:0] taken_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_BCOND = 2'b00;
    localparam logic [1:0] TYPE_CBZ   = 2'b01;
    localparam logic [1:0] TYPE_CBNZ  = 2'b10;

    state_t                 state_q, state_d;
    logic [3:0]             flags_q, flags_d;
    logic                   taken_q, taken_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [3:0] incoming_flags;
    logic [3:0] eval_flags;
    logic       accept;
    logic       raw_taken;

    // f is ordered {N,Z,C,V}
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic met;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: met = z;
            4'b0001: met = !z;
            4'b0010: met = c;
            4'b0011: met = !c;
            4'b0100: met = n;
            4'b0101: met = !n;
            4'b0110: met = v;
            4'b0111: met = !v;
            4'b1000: met = c & !z;
            4'b1001: met = !c | z;
            4'b1010: met = (n == v);
            4'b1011: met = (n != v);
            4'b1100: met = !z & (n == v);
            4'b1101: met = z | (n != v);
            default: met = 1'b1;
        endcase
        return met;
    endfunction

    always_comb begin
        incoming_flags = {negative_i, zero_i, carry_i, overflow_i};
        eval_flags     = (BYPASS && set_flags_i) ? incoming_flags : flags_q;
        accept         = br_valid_i & ~flush_i;

        case (br_type_i)
            TYPE_BCOND: raw_taken = cond_met(cond_i, eval_flags);
            TYPE_CBZ:   raw_taken = reg_zero_i;
            TYPE_CBNZ:  raw_taken = !reg_zero_i;
            default:    raw_taken = 1'b1;
        endcase

        flags_d = set_flags_i ? incoming_flags : flags_q;
        state_d = accept ? DONE : IDLE;
        // Gate with accept so don't-care inputs never leak into the pulse
        taken_d = accept & raw_taken;
        count_d = count_q;
        if (taken_d && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
            taken_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
            count_q <= count_d;
        end
    end

    assign flags_o       = flags_q;
    assign br_done_o     = (state_q == DONE);
    assign br_taken_o    = taken_q;
    assign taken_count_o = count_q;

endmodule

// File: tb/tb_cond_branch_resolver.sv
// Directed bench for cond_branch_resolver: a BYPASS=1/16-bit instance and a
// BYPASS=0/4-bit instance driven by the same stimulus.
module tb_cond_branch_resolver;

    logic        clk_i;
    logic        reset_i;
    logic        set_flags_i;
    logic        zero_i;
    logic        negative_i;
    logic        carry_i;
    logic        overflow_i;
    logic        br_valid_i;
    logic [1:0]  br_type_i;
    logic [3:0]  cond_i;
    logic        reg_zero_i;
    logic        flush_i;

    logic [3:0]  flags_a, flags_b;
    logic        done_a, done_b;
    logic        taken_a, taken_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int vectors;
    int miscompares;
    logic [15:0] exp_cnt;

    cond_branch_resolver #(.BYPASS(1'b1), .COUNT_WIDTH(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .set_flags_i(set_flags_i),
        .zero_i(zero_i), .negative_i(negative_i), .carry_i(carry_i),
        .overflow_i(overflow_i), .br_valid_i(br_valid_i), .br_type_i(br_type_i),
        .cond_i(cond_i), .reg_zero_i(reg_zero_i), .flush_i(flush_i),
        .flags_o(flags_a), .br_done_o(done_a), .br_taken_o(taken_a),
        .taken_count_o(count_a)
    );

    cond_branch_resolver #(.BYPASS(1'b0), .COUNT_WIDTH(4)) dut_nb (
        .clk_i(clk_i), .reset_i(reset_i), .set_flags_i(set_flags_i),
        .zero_i(zero_i), .negative_i(negative_i), .carry_i(carry_i),
        .overflow_i(overflow_i), .br_valid_i(br_valid_i), .br_type_i(br_type_i),
        .cond_i(cond_i), .reg_zero_i(reg_zero_i), .flush_i(flush_i),
        .flags_o(flags_b), .br_done_o(done_b), .br_taken_o(taken_b),
        .taken_count_o(count_b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the edge
    task automatic applyStimulus(input logic rst, input logic sf, input logic [3:0] nzcv,
                                 input logic valid, input logic [1:0] btype,
                                 input logic [3:0] cond, input logic rz, input logic fl);
        reset_i     = rst;
        set_flags_i = sf;
        negative_i  = nzcv[3];
        zero_i      = nzcv[2];
        carry_i     = nzcv[1];
        overflow_i  = nzcv[0];
        br_valid_i  = valid;
        br_type_i   = btype;
        cond_i      = cond;
        reg_zero_i  = rz;
        flush_i     = fl;
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0]  sweep_nzcv [7];
    logic [15:0] sweep_mask [7];

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 16'd0;

        sweep_nzcv[0] = 4'b0000; sweep_mask[0] = 16'hD6AA;
        sweep_nzcv[1] = 4'b0100; sweep_mask[1] = 16'hE6A9;
        sweep_nzcv[2] = 4'b1000; sweep_mask[2] = 16'hEA9A;
        sweep_nzcv[3] = 4'b0001; sweep_mask[3] = 16'hEA6A;
        sweep_nzcv[4] = 4'b1001; sweep_mask[4] = 16'hD65A;
        sweep_nzcv[5] = 4'b0010; sweep_mask[5] = 16'hD5A6;
        sweep_nzcv[6] = 4'b0110; sweep_mask[6] = 16'hE6A5;

        // Reset wins over a simultaneous request and flag write
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1, 2'b11, 4'h0, 1'b0, 1'b0);
        checkOutput("rst_flags", flags_a, 4'b0000);
        checkOutput("rst_done", done_a, 1'b0);
        checkOutput("rst_taken", taken_a, 1'b0);
        checkOutput("rst_count", count_a, 16'd0);
        checkOutput("rst_count_nb", count_b, 4'd0);

        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
        checkOutput("t1_flags", flags_a, 4'b0100);
        checkOutput("t1_idle_done", done_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
        exp_cnt++;
        checkOutput("t1_eq_done", done_a, 1'b1);
        checkOutput("t1_eq_taken", taken_a, 1'b1);
        checkOutput("t1_count", count_a, exp_cnt);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
        checkOutput("t1_done_clear", done_a, 1'b0);
        checkOutput("t1_taken_clear", taken_a, 1'b0);

        // Bypass: same-cycle N=1,V=0 flips LT for BYPASS=1 only
        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b1, 2'b00, 4'b1011, 1'b0, 1'b0);
        exp_cnt++;
        checkOutput("t2_byp_done", done_a, 1'b1);
        checkOutput("t2_byp_taken", taken_a, 1'b1);
        checkOutput("t2_nobyp_done", done_b, 1'b1);
        checkOutput("t2_nobyp_taken", taken_b, 1'b0);
        checkOutput("t2_flags", flags_a, 4'b1000);
        checkOutput("t2_flags_nb", flags_b, 4'b1000);

        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b01, 4'b0001, 1'b1, 1'b0);
        exp_cnt++;
        checkOutput("t3_cbz_done", done_a, 1'b1);
        checkOutput("t3_cbz_taken", taken_a, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 4'b1110, 1'b1, 1'b0);
        checkOutput("t3_cbnz_done", done_a, 1'b1);
        checkOutput("t3_cbnz_taken", taken_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 4'b0000, 1'b0, 1'b0);
        exp_cnt++;
        checkOutput("t3_b_done", done_a, 1'b1);
        checkOutput("t3_b_taken", taken_a, 1'b1);
        checkOutput("t3_count", count_a, exp_cnt);

        for (int s = 0; s < 7; s++) begin
            applyStimulus(1'b0, 1'b1, sweep_nzcv[s], 1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("t4_flags_%b", sweep_nzcv[s]), flags_a, sweep_nzcv[s]);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 4'(c), 1'b0, 1'b0);
                if (sweep_mask[s][c]) exp_cnt++;
                checkOutput($sformatf("t4_done_%b_%0d", sweep_nzcv[s], c), done_a, 1'b1);
                checkOutput($sformatf("t4_taken_%b_%0d", sweep_nzcv[s], c), taken_a, sweep_mask[s][c]);
            end
            checkOutput($sformatf("t4_count_%b", sweep_nzcv[s]), count_a, exp_cnt);
        end

        // Flush cancels a request following a visible decision, flags still written
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h0, 1'b0, 1'b0);
        exp_cnt++;
        checkOutput("t5_pre_done", done_a, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 2'b11, 4'h0, 1'b0, 1'b1);
        checkOutput("t5_flush_done", done_a, 1'b0);
        checkOutput("t5_flush_taken", taken_a, 1'b0);
        checkOutput("t5_flush_count", count_a, exp_cnt);
        checkOutput("t5_flush_flags", flags_a, 4'b1111);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h0, 1'b0, 1'b0);
        exp_cnt++;
        checkOutput("t5_b_done", done_a, 1'b1);
        checkOutput("t5_b_count", count_a, exp_cnt);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h0, 1'b0, 1'b0);
        exp_cnt = 16'd0;
        checkOutput("t5_rst_done", done_a, 1'b0);
        checkOutput("t5_rst_taken", taken_a, 1'b0);
        checkOutput("t5_rst_flags", flags_a, 4'b0000);
        checkOutput("t5_rst_count", count_a, exp_cnt);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 2'b11, 4'b1110, 1'b1, 1'b0);
        checkOutput("t5_novalid_done", done_a, 1'b0);
        checkOutput("t5_novalid_taken", taken_a, 1'b0);
        checkOutput("t5_novalid_count", count_a, 16'd0);

        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("t6_count16_%0d", i), count_a, 16'(i));
            checkOutput($sformatf("t6_count4_%0d", i), count_b, (i > 15) ? 4'hF : 4'(i));
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
        checkOutput("t6_sat_hold", count_b, 4'hF);
        checkOutput("t6_idle_done", done_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
